writeback_stage: RTL and testbench

Parametrised writeback stage between the datapath result sources and the register-file write port. It selects one of NSRC result sources per instruction, tags the result with its destination register, and buffers it in a DEPTH-entry FIFO so register-file write stalls do not stall the datapath. It also forwards buffered, not-yet-written values to the operand-read logic. It is the multi-source, buffered successor of the two-input writeback multiplexer.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 78 +++++++
 rtl/writeback_stage.sv | 124 ++++++++++++
 tb/tb_writeback_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: result-source indices and the
// default-width buffered entry used by neighbouring blocks and benches.
package wb_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC  = 2;
  localparam int SRC_IMM = 3;

  localparam int WB_DW   = 16;
  localparam int WB_NREG = 8;

  typedef struct packed {
    logic [$clog2(WB_NREG)-1:0] dest;
    logic [WB_DW-1:0]           data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO that also exposes every slot in age order
// (index 0 = head/oldest) with an occupancy mask, for forwarding compares.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [W-1:0]                  wdata,
  input  logic                          pop,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0][W-1:0]       age_data,
  output logic [DEPTH-1:0]              age_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Pointers are power-of-two wide, so the age-to-slot sum wraps for free.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [AW-1:0] phys;
    assign phys          = rd_ptr_q + AW'(gi);
    assign age_data[gi]  = mem_q[phys];
    assign age_valid[gi] = (CW'(gi) < count_q);
  end

endmodule

// File: rtl/writeback_stage.sv
// Multi-source buffered writeback: selects a result source, queues it with its
// destination register, and forwards queued values to operand reads.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NSRC  = 4,
  parameter int NREG  = 8,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(NSRC)-1:0]   in_vsel,
  input  logic [NSRC*DW-1:0]        in_src,
  input  logic [$clog2(NREG)-1:0]   in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NREG)-1:0]   out_dest,
  output logic [DW-1:0]             out_data,
  input  logic [$clog2(NREG)-1:0]   fwd_rnum,
  output logic                      fwd_hit,
  output logic [DW-1:0]             fwd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      sel_err
);

  localparam int SW = $clog2(NSRC);
  localparam int RW = $clog2(NREG);
  localparam int EW = RW + DW;

  typedef struct packed {
    logic [RW-1:0] dest;
    logic [DW-1:0] data;
  } entry_t;

  logic [DW-1:0]          src_arr [NSRC];
  logic [DW-1:0]          sel_data;
  logic                   vsel_ok;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  entry_t                 wr_entry;
  logic [DEPTH-1:0][EW-1:0] age_data;
  logic [DEPTH-1:0]       age_valid;
  entry_t                 age_ent [DEPTH];
  logic                   sel_err_q, sel_err_d;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src_arr[gi] = in_src[gi*DW +: DW];
  end

  // Unmatched selects (only reachable for non-power-of-two NSRC) yield zero.
  always_comb begin
    sel_data = '0;
    vsel_ok  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (in_vsel == SW'(i)) begin
        sel_data = src_arr[i];
        vsel_ok  = 1'b1;
      end
    end
  end

  assign in_ready      = !fifo_full;
  assign push          = in_valid && in_ready;
  assign wr_entry.dest = in_dest;
  assign wr_entry.data = sel_data;

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     (wr_entry),
    .pop       (out_ready),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .age_data  (age_data),
    .age_valid (age_valid)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign age_ent[gi] = entry_t'(age_data[gi]);
  end

  assign out_valid = !fifo_empty;
  assign out_dest  = out_valid ? age_ent[0].dest : '0;
  assign out_data  = out_valid ? age_ent[0].data : '0;

  // Walk oldest to youngest so the youngest matching entry overrides older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (age_valid[a] && (age_ent[a].dest == fwd_rnum)) begin
        fwd_hit  = 1'b1;
        fwd_data = age_ent[a].data;
      end
    end
  end

  always_comb begin
    sel_err_d = sel_err_q;
    if (push && !vsel_ok) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected entries go into a scoreboard
// queue on acceptance; a negedge monitor checks every pop against it.
module tb_writeback_stage;
  import wb_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic              in_valid, in_ready, out_valid, out_ready, fwd_hit, sel_err;
  logic [1:0]        in_vsel;
  logic [4*DW-1:0]   in_src;
  logic [2:0]        in_dest, out_dest, fwd_rnum;
  logic [DW-1:0]     out_data, fwd_data;
  logic [1:0]        count;

  // NSRC=3 instance
  logic              u3_in_valid, u3_in_ready, u3_out_valid, u3_fwd_hit, u3_sel_err;
  logic [1:0]        u3_in_vsel;
  logic [3*DW-1:0]   u3_in_src;
  logic [2:0]        u3_in_dest, u3_out_dest;
  logic [DW-1:0]     u3_out_data, u3_fwd_data;
  logic [1:0]        u3_count;

  writeback_stage #(.DW(DW), .NSRC(4), .NREG(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vsel(in_vsel),
    .in_src(in_src), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_data(out_data), .fwd_rnum(fwd_rnum), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .count(count), .sel_err(sel_err)
  );

  writeback_stage #(.DW(DW), .NSRC(3), .NREG(8), .DEPTH(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(u3_in_valid), .in_ready(u3_in_ready), .in_vsel(u3_in_vsel),
    .in_src(u3_in_src), .in_dest(u3_in_dest),
    .out_valid(u3_out_valid), .out_ready(1'b1), .out_dest(u3_out_dest),
    .out_data(u3_out_data), .fwd_rnum(3'd0), .fwd_hit(u3_fwd_hit),
    .fwd_data(u3_fwd_data), .count(u3_count), .sel_err(u3_sel_err)
  );

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  wb_entry_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] mk_src(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                             input logic [DW-1:0] s2, input logic [DW-1:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  // Monitor: a pop happens at the next posedge when valid&&ready are seen here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", {29'd0, out_dest}, 32'hFFFF_FFFF);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        pops++;
        $display("pop %0d dest=%0d data=0x%04h (want dest=%0d data=0x%04h)",
                 pops, out_dest, out_data, e.dest, e.data);
        chk("pop_dest", {29'd0, out_dest}, {29'd0, e.dest});
        chk("pop_data", {16'd0, out_data}, {16'd0, e.data});
      end
    end
  end

  task automatic push(input logic [1:0] vsel, input logic [4*DW-1:0] src, input logic [2:0] dest);
    bit ok;
    wb_entry_t e;
    in_valid = 1'b1;
    in_vsel  = vsel;
    in_src   = src;
    in_dest  = dest;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        e.dest = dest;
        e.data = src[int'(vsel)*DW +: DW];
        exp_q.push_back(e);
        $display("push dest=%0d vsel=%0d data=0x%04h", dest, vsel, e.data);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 50 && count != 2'd0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain", {30'd0, count}, 32'd0);
  endtask

  task automatic u3_push(input logic [1:0] vsel, input logic [2:0] dest);
    u3_in_valid = 1'b1;
    u3_in_vsel  = vsel;
    u3_in_dest  = dest;
    @(negedge clk);
    chk("u3_in_ready", {31'd0, u3_in_ready}, 32'd1);
    @(posedge clk); #1;
    u3_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_vsel = '0; in_src = '0; in_dest = '0;
    out_ready = 1'b0; fwd_rnum = '0;
    u3_in_valid = 1'b0; u3_in_vsel = '0; u3_in_dest = '0;
    u3_in_src = {16'h3333, 16'h2222, 16'h1111};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);

    // Single push through the stage
    out_ready = 1'b1;
    push(SRC_MEM[1:0], mk_src(16'h0000, 16'h1234, 16'h0000, 16'h0000), 3'd3);
    chk("t1_count_after_push", {30'd0, count}, 32'd1);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("t1_count_after_pop", {30'd0, count}, 32'd0);
    chk("t1_out_dest_empty", {29'd0, out_dest}, 32'd0);

    // Fill while stalled, third held until space frees
    out_ready = 1'b0;
    push(2'd0, mk_src(16'h0101, 16'h0, 16'h0, 16'h0), 3'd1);
    push(2'd2, mk_src(16'h0, 16'h0, 16'h0202, 16'h0), 3'd2);
    chk("t2_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_full_count", {30'd0, count}, 32'd2);
    in_valid = 1'b1; in_vsel = 2'd3; in_src = mk_src(16'h0, 16'h0, 16'h0, 16'h0303); in_dest = 3'd4;
    @(negedge clk);
    chk("t2_held_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t2_held_count", {30'd0, count}, 32'd2);
    out_ready = 1'b1;
    push(2'd3, mk_src(16'h0, 16'h0, 16'h0, 16'h0303), 3'd4);
    wait_empty();

    // Youngest-match forwarding
    out_ready = 1'b0;
    fwd_rnum  = 3'd5;
    push(SRC_ALU[1:0], mk_src(16'h0AAA, 16'h0, 16'h0, 16'h0), 3'd5);
    in_valid = 1'b1; in_vsel = SRC_IMM[1:0]; in_src = mk_src(16'h0, 16'h0, 16'h0, 16'h0BBB); in_dest = 3'd5;
    #1;
    chk("t3_pushing_not_fwd", {16'd0, fwd_data}, 32'h0AAA);
    push(SRC_IMM[1:0], mk_src(16'h0, 16'h0, 16'h0, 16'h0BBB), 3'd5);
    chk("t3_fwd_hit", {31'd0, fwd_hit}, 32'd1);
    chk("t3_fwd_youngest", {16'd0, fwd_data}, 32'h0BBB);
    fwd_rnum = 3'd2; #1;
    chk("t3_miss_hit", {31'd0, fwd_hit}, 32'd0);
    chk("t3_miss_data", {16'd0, fwd_data}, 32'd0);
    fwd_rnum = 3'd5;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_popping_fwd_hit", {31'd0, fwd_hit}, 32'd1);
    chk("t3_popping_fwd_data", {16'd0, fwd_data}, 32'h0BBB);
    @(posedge clk); #1;
    chk("t3_empty_fwd_hit", {31'd0, fwd_hit}, 32'd0);

    // Sustained push+pop at count=1, pointers wrap
    for (int i = 0; i < 11; i++) begin
      logic [DW-1:0] v;
      v = DW'(16'h5000 + i * 16'h0111);
      push(2'(i % 4), mk_src(v, v ^ 16'h00F0, v ^ 16'h0F00, v ^ 16'hF000), 3'(i % 8));
      chk("t4_count_steady", {30'd0, count}, 32'd1);
    end
    wait_empty();

    // Reset mid-stream while full
    out_ready = 1'b0;
    fwd_rnum  = 3'd4;
    push(2'd1, mk_src(16'h0, 16'h7777, 16'h0, 16'h0), 3'd4);
    push(2'd2, mk_src(16'h0, 16'h0, 16'h8888, 16'h0), 3'd6);
    chk("t5_full_count", {30'd0, count}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    chk("t5_rst_count", {30'd0, count}, 32'd0);
    chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    chk("t5_rst_out_data", {16'd0, out_data}, 32'd0);

    // NSRC=3: out-of-range select stores zero and latches sel_err
    chk("t6_sel_err_init", {31'd0, u3_sel_err}, 32'd0);
    u3_push(2'd2, 3'd2);
    @(negedge clk);
    chk("t6_src2_data", {16'd0, u3_out_data}, 32'h3333);
    chk("t6_src2_sel_err", {31'd0, u3_sel_err}, 32'd0);
    @(posedge clk); #1;
    u3_push(2'd3, 3'd7);
    @(negedge clk);
    chk("t6_bad_valid", {31'd0, u3_out_valid}, 32'd1);
    chk("t6_bad_dest", {29'd0, u3_out_dest}, 32'd7);
    chk("t6_bad_data", {16'd0, u3_out_data}, 32'd0);
    chk("t6_sel_err_set", {31'd0, u3_sel_err}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_sel_err_sticky", {31'd0, u3_sel_err}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_sel_err_cleared", {31'd0, u3_sel_err}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
